// File: rtl/rns_to_int_seq.sv
// Sequential RNS-to-integer back-converter: bit-serial CRT reconstruction modulo M,
// followed by a signed mapping of the reconstructed value onto 32-bit two's complement.
module rns_to_int_seq #(
    parameter logic [7:0]  B0    = 8'd233,
    parameter logic [7:0]  B1    = 8'd239,
    parameter logic [7:0]  B2    = 8'd241,
    parameter logic [7:0]  B3    = 8'd251,
    parameter logic [31:0] A0    = 32'd3021585941,
    parameter logic [31:0] A1    = 32'd1099363434,
    parameter logic [31:0] A2    = 32'd1663315003,
    parameter logic [31:0] A3    = 32'd952860257,
    parameter logic [31:0] M     = 32'd3368562317,
    parameter logic [31:0] MID   = 32'd1684281159,
    parameter logic [31:0] DELTA = 32'd926404979
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rns,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_number,
    output logic        out_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [32:0] M_EXT = {1'b0, M};

    state_t      state_q;
    logic [31:0] rns_q;
    logic        err_q;
    logic [4:0]  cnt_q;
    logic [31:0] p_q;
    logic [31:0] sum_q;
    logic [31:0] int_q;
    logic        out_err_q;

    logic [7:0]  cur_res;
    logic        cur_bit;
    logic [31:0] a_sel;
    logic [31:0] dbl_d;
    logic [31:0] p_d;
    logic [31:0] sum_d;
    logic [31:0] mapped_d;

    // Operands are always below M, so one conditional subtract brings x back into range.
    function automatic logic [31:0] fold(input logic [32:0] x);
        return 32'(x >= M_EXT ? x - M_EXT : x);
    endfunction

    always_comb begin
        cur_res = rns_q[{cnt_q[4:3], 3'b000} +: 8];
        cur_bit = cur_res[~cnt_q[2:0]];
        case (cnt_q[4:3])
            2'd0:    a_sel = A0;
            2'd1:    a_sel = A1;
            2'd2:    a_sel = A2;
            default: a_sel = A3;
        endcase
        dbl_d    = fold({p_q, 1'b0});
        p_d      = fold({1'b0, dbl_d} + {1'b0, (cur_bit ? a_sel : 32'd0)});
        sum_d    = fold({1'b0, sum_q} + {1'b0, p_d});
        mapped_d = (sum_d >= MID) ? sum_d + DELTA : sum_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rns_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            p_q       <= '0;
            sum_q     <= '0;
            int_q     <= '0;
            out_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rns_q   <= rns;
                        err_q   <= (rns[7:0] >= B0) || (rns[15:8] >= B1) ||
                                   (rns[23:16] >= B2) || (rns[31:24] >= B3);
                        cnt_q   <= '0;
                        p_q     <= '0;
                        sum_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    // Each residue's partial product r_i*A_i is folded into sum after its 8th bit.
                    if (cnt_q[2:0] == 3'd7) begin
                        sum_q <= sum_d;
                        p_q   <= '0;
                    end else begin
                        p_q   <= p_d;
                    end
                    if (cnt_q == 5'd31) begin
                        int_q     <= mapped_d;
                        out_err_q <= err_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign int_number = int_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_rns_to_int_seq.sv
// Self-checking bench for rns_to_int_seq: arithmetic CRT reference model plus
// per-cycle output comparison, directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_rns_to_int_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rns = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] int_number;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam longint unsigned M_L     = 64'd3368562317;
    localparam longint unsigned MID_L   = 64'd1684281159;
    localparam longint unsigned DELTA_L = 64'd926404979;

    always #5 clk = ~clk;

    rns_to_int_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rns        (rns),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .int_number (int_number),
        .out_err    (out_err),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: x = sum(r_i * A_i) mod M, then signed mapping.
    function automatic logic [31:0] ref_int(input logic [31:0] w);
        longint unsigned a [4];
        longint unsigned s;
        a = '{64'd3021585941, 64'd1099363434, 64'd1663315003, 64'd952860257};
        s = 0;
        for (int i = 0; i < 4; i++) s = s + 64'(w[8*i +: 8]) * a[i];
        s = s % M_L;
        if (s >= MID_L) s = s + DELTA_L;
        return s[31:0];
    endfunction

    function automatic logic ref_err(input logic [31:0] w);
        return (w[7:0] >= 8'd233) || (w[15:8] >= 8'd239) ||
               (w[23:16] >= 8'd241) || (w[31:24] >= 8'd251);
    endfunction

    function automatic logic [31:0] to_rns(input longint unsigned v);
        logic [31:0] r;
        r[7:0]   = 8'(v % 233);
        r[15:8]  = 8'(v % 239);
        r[23:16] = 8'(v % 241);
        r[31:24] = 8'(v % 251);
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        longint unsigned v;
        if ($urandom_range(0, 7) == 0) return $urandom;
        if ($urandom_range(0, 3) == 0) v = MID_L - 64'd2 + 64'($urandom_range(0, 3));
        else v = 64'($urandom) % M_L;
        return to_rns(v);
    endfunction

    // Transaction-level timing model: 32 cycles of work after acceptance, then hold until taken.
    int          m_state = 0;
    int          m_left  = 0;
    logic [31:0] m_int = '0, m_pend_int = '0;
    logic        m_err = 1'b0, m_pend_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_left  <= 0;
            m_int   <= '0;
            m_err   <= 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_pend_int <= ref_int(rns);
                    m_pend_err <= ref_err(rns);
                    m_left     <= 32;
                    m_state    <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_int   <= m_pend_int;
                        m_err   <= m_pend_err;
                        m_state <= 2;
                    end
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready",   32'(in_ready),  32'(m_state == 0));
        chk("out_valid",  32'(out_valid), 32'(m_state == 2));
        chk("busy",       32'(busy),      32'(m_state != 0));
        chk("int_number", int_number,     m_int);
        chk("out_err",    32'(out_err),   32'(m_err));
        if (out_valid && out_ready && !rst)
            $display("result int_number=0x%08h out_err=%0d at %0t", int_number, out_err, $time);
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] w, input logic [31:0] exp_int,
                           input logic exp_err, input logic check_int);
        int   edges;
        logic ready_low_ok;
        wait_idle();
        in_valid = 1'b1;
        rns = w;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        rns = $urandom;
        ready_low_ok = 1'b1;
        while (!out_valid && edges < 100) begin
            if (in_ready) ready_low_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(edges), 32'd33);
        chk({tag, "_inready_low"}, 32'(ready_low_ok), 32'd1);
        if (check_int) chk({tag, "_int"}, int_number, exp_int);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    endtask

    initial begin
        int   acc [$];
        logic ir;
        int   guard;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_int",       int_number,     32'd0);
        chk("rst_err",       32'(out_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("model_5",    ref_int(32'h05050505), 32'h00000005);
        chk("model_m1",   ref_int(32'hFAF0EEE8), 32'hFFFFFFFF);
        chk("model_m5",   ref_int(32'hF6ECEAE4), 32'hFFFFFFFB);
        chk("model_rns5", to_rns(64'd5),         32'h05050505);
        rst = 1'b0;

        run_one("zero",  32'h00000000, 32'h00000000, 1'b0, 1'b1);
        run_one("five",  32'h05050505, 32'h00000005, 1'b0, 1'b1);
        run_one("neg1",  32'hFAF0EEE8, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_one("neg5",  32'hF6ECEAE4, 32'hFFFFFFFB, 1'b0, 1'b1);
        run_one("err_r0", 32'h000000E9, 32'h0, 1'b1, 1'b0);
        run_one("err_r3", 32'hFB000000, 32'h0, 1'b1, 1'b0);

        // Back-to-back acceptance spacing with out_ready held high.
        wait_idle();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c != 0) @(negedge clk);
            ir = in_ready;
            if (ir) rns = rand_word();
            @(posedge clk);
            if (ir) acc.push_back(c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() >= 3) begin
            chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd34);
            chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd34);
        end

        // Backpressure: result must hold while out_ready is low.
        wait_idle();
        out_ready = 1'b0;
        in_valid = 1'b1;
        rns = 32'h05050505;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_reached", 32'(out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_int_hold",   int_number,     32'h00000005);
            chk("bp_ready_low",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_int",   int_number,     32'h00000005);

        // Asynchronous reset in the middle of a conversion.
        in_valid = 1'b1;
        rns = 32'hF6ECEAE4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_int",   int_number,     32'd0);
        chk("mid_rst_err",   32'(out_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one("after_rst", 32'h05050505, 32'h00000005, 1'b0, 1'b1);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            rns       = rand_word();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
